reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_LEN, default 16: consecutive low samples of the synchronized external line that count as an external reset request.
REQ-002 SHALL have parameter STAGE_GAP, default 64: cycles between successive stage releases.
REQ-003 SHALL have parameter SW_PULSE_LEN, default 256: cycles the shared reset line is driven low for a software reset.
REQ-004 SHALL have port clk, input, 1: the single clock for all logic.
REQ-005 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port clk_ok, input, 1: clock-generator locked indication.
REQ-007 SHALL have port reset_line_n, input, 1: asynchronous sample of the shared open-drain board reset line.
REQ-008 SHALL have port reset_drive_n, output, 1: 0 pulls the shared line low, 1 releases it.
REQ-009 SHALL have port sw_rst_req, input, 1: software reset request, level-sampled.
REQ-010 SHALL have port sw_rst_ack, output, 1: one-cycle acknowledge of an accepted software request.
REQ-011 SHALL have port stage_reset, output, 4: active-high reset per subsystem stage, released in order bit 0 to bit 3.
REQ-012 SHALL have port busy, output, 1: high while any stage_reset bit is high or a pulse is in progress.

Function
REQ-013 SHALL pass reset_line_n through a 2-flop synchronizer before any use.
REQ-014 SHALL count consecutive low synchronized samples, saturating at DEBOUNCE_LEN; ext_req asserts when the count reaches DEBOUNCE_LEN; any high sample clears the count and ext_req in that same cycle.
REQ-015 SHALL implement states HOLD, RELEASE, RUN and PULSE.
REQ-016 HOLD: stage_reset=4'b1111, busy=1; the block SHALL go to RELEASE on the first cycle with clk_ok=1 and ext_req=0, loading the gap counter with STAGE_GAP-1 and the stage index with 0.
REQ-017 RELEASE: the gap counter SHALL decrement each cycle; at 0 it SHALL clear stage_reset[index], increment the index and reload; after clearing bit 3 the next state SHALL be RUN.
REQ-018 SHALL release stage_reset[k] exactly (k+1)*STAGE_GAP cycles after the first RELEASE cycle.
REQ-019 RUN: stage_reset=0 and busy=0.
REQ-020 In RELEASE or RUN, clk_ok=0 or ext_req=1 SHALL cause a transition to HOLD, with all stage_reset bits high on the next cycle; this condition has priority over sw_rst_req.
REQ-021 In RUN, sw_rst_req=1 SHALL cause PULSE entry, with sw_rst_ack high for exactly that transition cycle's successor (the first PULSE cycle).
REQ-022 sw_rst_req SHALL be ignored outside RUN, with no acknowledge.
REQ-023 PULSE SHALL hold reset_drive_n=0 and stage_reset=4'b1111 for exactly SW_PULSE_LEN cycles, then go to HOLD.
REQ-024 The debounce count SHALL be held at 0 during PULSE, so the block's own pulse never raises ext_req.
REQ-025 clk_ok loss during PULSE SHALL NOT shorten the pulse.
REQ-026 reset_drive_n SHALL be 1 in every state except PULSE.

Reset
REQ-027 reset_n=0 at a clock edge SHALL force: state HOLD; stage_reset=4'b1111; busy=1; reset_drive_n=1; sw_rst_ack=0; synchronizer flops=0; debounce count=0; ext_req=0; index=0; gap counter=0.
REQ-028 reset_n asserted mid-RELEASE or mid-PULSE SHALL abort the operation immediately, with no partial pulse continuation.

Configuration
REQ-029 With macro RESET_CAUSE_EN defined, the block SHALL have output rst_cause, 2 bits: 00 reset_n, 01 clk_ok loss, 10 external line, 11 software.
REQ-030 rst_cause SHALL update on each HOLD/PULSE entry, keep its value through RUN, and read 00 after reset_n.
REQ-031 Without RESET_CAUSE_EN, the port and its register SHALL be absent, with all other behaviour identical.

Verification
REQ-032 Release reset_n, clk_ok=1, line high -> stage_reset bits clear at cycles 64, 128, 192, 256 after the first RELEASE cycle; busy falls with bit 3.
REQ-033 In RUN, line low for 15 cycles then high -> no reset; line low for 20 cycles -> HOLD, stage_reset=4'b1111, rst_cause=10.
REQ-034 In RUN, sw_rst_req one cycle -> sw_rst_ack one cycle; reset_drive_n low for exactly 256 cycles, with the line looped back; then a full 4-stage release; rst_cause=11.
REQ-035 clk_ok drops during RELEASE after stage 1 is released -> next cycle stage_reset=4'b1111; after clk_ok returns, the release restarts from stage 0; rst_cause=01.
REQ-036 sw_rst_req and ext_req asserted in the same RUN cycle -> HOLD, no ack, reset_drive_n stays 1.
REQ-037 reset_n pulsed low mid-PULSE -> reset_drive_n=1 next cycle, state HOLD, rst_cause=00.

Source files
------------

// File: rtl/reset_sequencer.sv
// Reset sequencer: debounces the shared board reset line, releases four stage resets in order,
// and drives a software-requested pulse onto the line. Optional RESET_CAUSE_EN adds rst_cause.
module reset_sequencer #(
  parameter int DEBOUNCE_LEN = 16,
  parameter int STAGE_GAP    = 64,
  parameter int SW_PULSE_LEN = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_ok,
  input  logic       reset_line_n,
  output logic       reset_drive_n,
  input  logic       sw_rst_req,
  output logic       sw_rst_ack,
  output logic [3:0] stage_reset,
  output logic       busy
`ifdef RESET_CAUSE_EN
  ,
  output logic [1:0] rst_cause
`endif
);

  localparam int CW   = $clog2(DEBOUNCE_LEN + 1);
  localparam int TMAX = (STAGE_GAP > SW_PULSE_LEN) ? STAGE_GAP : SW_PULSE_LEN;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] DB_MAX     = CW'(DEBOUNCE_LEN);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(STAGE_GAP - 1);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(SW_PULSE_LEN - 1);

  typedef enum logic [1:0] {HOLD, RELEASE, RUN, PULSE} state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ext_req_q, ext_req_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      stage_q, stage_d;
  logic            ack_q, ack_d;
  logic            drive_n_q, drive_n_d;

  // Debounce is frozen during our own pulse so the looped-back line never looks external.
  always_comb begin
    sync1_d = reset_line_n;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    if (state_q == PULSE || sync2_q) cnt_d = '0;
    else if (cnt_q != DB_MAX)        cnt_d = cnt_q + CW'(1);
    ext_req_d = (cnt_d == DB_MAX);
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    ack_d   = 1'b0;
    unique case (state_q)
      HOLD: begin
        stage_d = 4'b1111;
        if (clk_ok && !ext_req_q) begin
          state_d = RELEASE;
          timer_d = GAP_LOAD;
          idx_d   = 2'd0;
        end
      end
      RELEASE: begin
        if (!clk_ok || ext_req_q) begin
          state_d = HOLD;
          stage_d = 4'b1111;
        end else if (timer_q == '0) begin
          stage_d[idx_q] = 1'b0;
          idx_d          = idx_q + 2'd1;
          timer_d        = GAP_LOAD;
          if (idx_q == 2'd3) state_d = RUN;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      RUN: begin
        stage_d = 4'b0000;
        if (!clk_ok || ext_req_q) begin
          state_d = HOLD;
          stage_d = 4'b1111;
        end else if (sw_rst_req) begin
          state_d = PULSE;
          stage_d = 4'b1111;
          timer_d = PULSE_LOAD;
          ack_d   = 1'b1;
        end
      end
      PULSE: begin
        // Runs to completion regardless of clk_ok.
        stage_d = 4'b1111;
        if (timer_q == '0) state_d = HOLD;
        else               timer_d = timer_q - TW'(1);
      end
      default: state_d = HOLD;
    endcase
    drive_n_d = (state_d != PULSE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= HOLD;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      ext_req_q <= 1'b0;
      timer_q   <= '0;
      idx_q     <= 2'd0;
      stage_q   <= 4'b1111;
      ack_q     <= 1'b0;
      drive_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      ext_req_q <= ext_req_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      stage_q   <= stage_d;
      ack_q     <= ack_d;
      drive_n_q <= drive_n_d;
    end
  end

  assign stage_reset   = stage_q;
  assign busy          = (state_q != RUN);
  assign sw_rst_ack    = ack_q;
  assign reset_drive_n = drive_n_q;

`ifdef RESET_CAUSE_EN
  logic [1:0] cause_q, cause_d;

  // Pulse completion re-enters HOLD but keeps the software cause; clk_ok loss outranks the line.
  always_comb begin
    cause_d = cause_q;
    if (state_d == PULSE && state_q != PULSE)
      cause_d = 2'b11;
    else if (state_d == HOLD && (state_q == RELEASE || state_q == RUN))
      cause_d = clk_ok ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cause_q <= 2'b00;
    else          cause_q <= cause_d;
  end

  assign rst_cause = cause_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer at default parameters; cause checks when RESET_CAUSE_EN is set.
module tb_reset_sequencer;
  logic       clk = 1'b0;
  logic       reset_n, clk_ok, line_drv, lb_en, sw_rst_req;
  logic       reset_line_n, reset_drive_n, sw_rst_ack, busy;
  logic [3:0] stage_reset;
`ifdef RESET_CAUSE_EN
  logic [1:0] rst_cause;
`endif

  int checks = 0;
  int failures = 0;
  int tick_no = 0;

  typedef struct {string name; int tick; logic [3:0] val;} exp_t;
  exp_t sb[$];

  assign reset_line_n = lb_en ? reset_drive_n : line_drv;

  reset_sequencer dut (
    .clk(clk), .reset_n(reset_n), .clk_ok(clk_ok), .reset_line_n(reset_line_n),
    .reset_drive_n(reset_drive_n), .sw_rst_req(sw_rst_req), .sw_rst_ack(sw_rst_ack),
    .stage_reset(stage_reset), .busy(busy)
`ifdef RESET_CAUSE_EN
    , .rst_cause(rst_cause)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      tick_no++;
    end
  endtask

  // Leaves the DUT just after the last reset edge; tick_no counts edges with reset_n high.
  task automatic apply_reset();
    reset_n = 1'b0; clk_ok = 1'b1; line_drv = 1'b1; lb_en = 1'b0; sw_rst_req = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick_no = 0;
  endtask

  task automatic wait_run(input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (!busy) begin t = tick_no; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clk_ok = 1'b1; line_drv = 1'b1; lb_en = 1'b0; sw_rst_req = 1'b1;
    tick(2);
    checks++; if (stage_reset !== 4'b1111) begin failures++; $display("FAIL reset_stage got=%b exp=1111", stage_reset); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (reset_drive_n !== 1'b1) begin failures++; $display("FAIL reset_drive got=%b exp=1", reset_drive_n); end
    checks++; if (sw_rst_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", sw_rst_ack); end
`ifdef RESET_CAUSE_EN
    checks++; if (rst_cause !== 2'b00) begin failures++; $display("FAIL reset_cause got=%b exp=00", rst_cause); end
`endif
    sw_rst_req = 1'b0;
  endtask

  task automatic test_release();
    logic [3:0] prev;
    exp_t e;
    apply_reset();
    sb.push_back('{"rel0", 65, 4'b1110});
    sb.push_back('{"rel1", 129, 4'b1100});
    sb.push_back('{"rel2", 193, 4'b1000});
    sb.push_back('{"rel3", 257, 4'b0000});
    prev = stage_reset;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (stage_reset !== prev) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL release_unexpected tick=%0d stage=%b", tick_no, stage_reset);
        end else begin
          e = sb.pop_front();
          if (tick_no != e.tick || stage_reset !== e.val) begin
            failures++;
            $display("FAIL %s got tick=%0d stage=%b exp tick=%0d stage=%b", e.name, tick_no, stage_reset, e.tick, e.val);
          end
          checks++;
          if (busy !== (e.val != 4'b0000)) begin failures++; $display("FAIL %s_busy got=%b", e.name, busy); end
        end
        prev = stage_reset;
      end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL release_missing left=%0d exp=0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_ext_debounce();
    int t;
    bit bad;
    bit seen;
    exp_t e;
    apply_reset();
    wait_run(400, t);
    checks++; if (t != 257) begin failures++; $display("FAIL ext_setup_run got=%0d exp=257", t); end
    tick(5);
    line_drv = 1'b0;
    tick(15);
    line_drv = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy !== 1'b0 || stage_reset !== 4'b0000) bad = 1;
    end
    checks++; if (bad) begin failures++; $display("FAIL ext_glitch15 got=reset exp=no_reset"); end
    tick(5);
    line_drv = 1'b0;
    tick_no = 0;
    sb.push_back('{"ext_hold", 19, 4'b1111});
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (tick_no == 20) line_drv = 1'b1;
      if (!seen && stage_reset !== 4'b0000) begin
        seen = 1;
        e = sb.pop_front();
        checks++;
        if (tick_no != e.tick || stage_reset !== e.val || busy !== 1'b1) begin
          failures++;
          $display("FAIL %s got tick=%0d stage=%b busy=%b exp tick=%0d stage=%b busy=1", e.name, tick_no, stage_reset, busy, e.tick, e.val);
        end
`ifdef RESET_CAUSE_EN
        checks++; if (rst_cause !== 2'b10) begin failures++; $display("FAIL ext_cause got=%b exp=10", rst_cause); end
`endif
      end
    end
    checks++; if (!seen) begin failures++; $display("FAIL ext_hold got=no_hold exp=hold"); end
    line_drv = 1'b1;
    sb.delete();
  endtask

  task automatic test_sw_pulse();
    int t, low;
    exp_t e;
    apply_reset();
    wait_run(400, t);
    lb_en = 1'b1;
    sw_rst_req = 1'b1;
    tick_no = 0;
    sb.push_back('{"sw_low", 256, 4'b1111});
    sb.push_back('{"sw_run", 514, 4'b0000});
    tick();
    sw_rst_req = 1'b0;
    checks++; if (sw_rst_ack !== 1'b1) begin failures++; $display("FAIL sw_ack got=%b exp=1", sw_rst_ack); end
    checks++; if (stage_reset !== 4'b1111 || reset_drive_n !== 1'b0) begin
      failures++; $display("FAIL sw_pulse_start got stage=%b drive=%b exp stage=1111 drive=0", stage_reset, reset_drive_n);
    end
    low = (reset_drive_n === 1'b0) ? 1 : 0;
    tick();
    checks++; if (sw_rst_ack !== 1'b0) begin failures++; $display("FAIL sw_ack_len got=%b exp=0", sw_rst_ack); end
    if (reset_drive_n === 1'b0) low++;
    t = -1;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (reset_drive_n === 1'b0) low++;
      if (!busy) begin t = tick_no; break; end
    end
    e = sb.pop_front();
    checks++; if (low != e.tick) begin failures++; $display("FAIL %s got=%0d exp=%0d", e.name, low, e.tick); end
    e = sb.pop_front();
    checks++; if (t != e.tick || stage_reset !== e.val) begin
      failures++; $display("FAIL %s got tick=%0d stage=%b exp tick=%0d stage=%b", e.name, t, stage_reset, e.tick, e.val);
    end
`ifdef RESET_CAUSE_EN
    checks++; if (rst_cause !== 2'b11) begin failures++; $display("FAIL sw_cause got=%b exp=11", rst_cause); end
`endif
    lb_en = 1'b0;
    sb.delete();
  endtask

  task automatic test_clk_loss();
    bit acked;
    logic [3:0] prev;
    exp_t e;
    apply_reset();
    tick(130);
    checks++; if (stage_reset !== 4'b1100) begin failures++; $display("FAIL clk_pre got=%b exp=1100", stage_reset); end
    clk_ok = 1'b0;
    tick();
    checks++; if (stage_reset !== 4'b1111) begin failures++; $display("FAIL clk_loss_hold got=%b exp=1111", stage_reset); end
`ifdef RESET_CAUSE_EN
    checks++; if (rst_cause !== 2'b01) begin failures++; $display("FAIL clk_cause got=%b exp=01", rst_cause); end
`endif
    acked = 0;
    sw_rst_req = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); if (sw_rst_ack) acked = 1; end
    sw_rst_req = 1'b0;
    clk_ok = 1'b1;
    sb.push_back('{"clk_rel0", 200, 4'b1110});
    sb.push_back('{"clk_rel1", 264, 4'b1100});
    prev = stage_reset;
    while (tick_no < 270) begin
      sw_rst_req = (tick_no >= 140 && tick_no < 150);
      tick();
      if (sw_rst_ack) acked = 1;
      if (stage_reset !== prev) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL clk_unexpected tick=%0d stage=%b", tick_no, stage_reset);
        end else begin
          e = sb.pop_front();
          if (tick_no != e.tick || stage_reset !== e.val) begin
            failures++;
            $display("FAIL %s got tick=%0d stage=%b exp tick=%0d stage=%b", e.name, tick_no, stage_reset, e.tick, e.val);
          end
        end
        prev = stage_reset;
      end
    end
    sw_rst_req = 1'b0;
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL clk_restart_missing left=%0d exp=0", sb.size()); end
    checks++; if (acked) begin failures++; $display("FAIL sw_ignored got=ack exp=no_ack"); end
    sb.delete();
  endtask

  task automatic test_sw_ext_same();
    int t;
    apply_reset();
    wait_run(400, t);
    tick(5);
    line_drv = 1'b0;
    tick(18);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL same_prerun got busy=%b exp=0", busy); end
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    checks++; if (stage_reset !== 4'b1111 || sw_rst_ack !== 1'b0 || reset_drive_n !== 1'b1) begin
      failures++; $display("FAIL same_cycle got stage=%b ack=%b drive=%b exp stage=1111 ack=0 drive=1", stage_reset, sw_rst_ack, reset_drive_n);
    end
    tick();
    checks++; if (sw_rst_ack !== 1'b0 || reset_drive_n !== 1'b1) begin
      failures++; $display("FAIL same_after got ack=%b drive=%b exp ack=0 drive=1", sw_rst_ack, reset_drive_n);
    end
`ifdef RESET_CAUSE_EN
    checks++; if (rst_cause !== 2'b10) begin failures++; $display("FAIL same_cause got=%b exp=10", rst_cause); end
`endif
    line_drv = 1'b1;
  endtask

  task automatic test_reset_mid_pulse();
    int t;
    bit resumed;
    apply_reset();
    wait_run(400, t);
    lb_en = 1'b1;
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    tick(100);
    checks++; if (reset_drive_n !== 1'b0) begin failures++; $display("FAIL mid_pulse got drive=%b exp=0", reset_drive_n); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++; if (reset_drive_n !== 1'b1 || stage_reset !== 4'b1111 || busy !== 1'b1 || sw_rst_ack !== 1'b0) begin
      failures++; $display("FAIL abort_pulse got drive=%b stage=%b busy=%b ack=%b exp drive=1 stage=1111 busy=1 ack=0",
                           reset_drive_n, stage_reset, busy, sw_rst_ack);
    end
`ifdef RESET_CAUSE_EN
    checks++; if (rst_cause !== 2'b00) begin failures++; $display("FAIL abort_cause got=%b exp=00", rst_cause); end
`endif
    resumed = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (reset_drive_n !== 1'b1) resumed = 1; end
    checks++; if (resumed) begin failures++; $display("FAIL abort_continue got=drive_low exp=drive_high"); end
    lb_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_release();
    test_ext_debounce();
    test_sw_pulse();
    test_clk_loss();
    test_sw_ext_same();
    test_reset_mid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
